// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants and state encoding for the instruction-memory loader
// Optional build: IMEM_LOADER_CHECKSUM_EN adds the CHECK state.
package imem_loader_pkg;
  localparam int ADDR_W         = 6;
  localparam int DEPTH          = 2 ** ADDR_W;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK = 3'd3,
`endif
    DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - load-request, byte-stream and memory-write signals of the loader
interface imem_loader_if #(
  parameter int ADDR_W = imem_loader_pkg::ADDR_W
);
  logic              start;
  logic [ADDR_W:0]   load_len;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, load_len, in_valid, in_byte,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err
  );

  modport slave (
    input  start, load_len, in_valid, in_byte,
    output in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs bytes MSB-first into 32-bit words
// word_full_o flags the shift that completes the current word.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);
  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (shift_i) begin
      word_d = {word_q[23:0], byte_i};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = shift_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams bytes into instruction memory while holding the CPU in reset
// Optional build: IMEM_LOADER_CHECKSUM_EN verifies a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = imem_loader_pkg::ADDR_W
) (
  input  logic        clk,
  input  logic        reset,
  imem_loader_if.slave bus
);
  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W:0]   len_q;
  logic              in_ready_q;
  logic              wr_en_q;
  logic              cpu_hold_q;
  logic              busy_q;
  logic              done_q;

  logic              accept;
  logic              data_accept;
  logic              clr_cnt;
  logic              last_word;
  logic              word_full;
  logic [31:0]       word;

  assign accept      = bus.in_valid && in_ready_q;
  assign data_accept = accept && (state_q == RECV);
  assign clr_cnt     = (state_q == IDLE) && bus.start;
  assign last_word   = ({1'b0, idx_q} == (len_q - (ADDR_W + 1)'(1)));

  word_assembler u_asm (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (clr_cnt),
    .shift_i     (data_accept),
    .byte_i      (bus.in_byte),
    .word_o      (word),
    .word_full_o (word_full)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      cpu_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            idx_q      <= '0;
            len_q      <= bus.load_len;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= '0;
            err_q      <= 1'b0;
`endif
            if (bus.load_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= RECV;
              in_ready_q <= 1'b1;
            end
          end
        end
        RECV: begin
          if (data_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q <= xor_q ^ bus.in_byte;
`endif
            if (word_full) begin
              state_q    <= WRITE;
              in_ready_q <= 1'b0;
              wr_en_q    <= 1'b1;
            end
          end
        end
        WRITE: begin
          idx_q <= idx_q + ADDR_W'(1);
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q    <= CHECK;
            in_ready_q <= 1'b1;
`else
            state_q <= DONE;
            done_q  <= 1'b1;
`endif
          end else begin
            state_q    <= RECV;
            in_ready_q <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            err_q      <= (bus.in_byte != xor_q);
            state_q    <= DONE;
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
`endif
        DONE: begin
          state_q    <= IDLE;
          cpu_hold_q <= 1'b0;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          cpu_hold_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // The assembler holds the finished word untouched while WRITE is active.
  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = idx_q;
  assign bus.wr_data  = word;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed and randomized checks of imem_loader against a byte-stream model
module tb_imem_loader;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bif ();
  imem_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bif));

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int rdy_bad = 0;
  logic [ADDR_W-1:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] exp_words[$];
  logic [7:0] bytes_q[$];

  always @(negedge clk) begin
    if (bif.wr_en) begin
      wa.push_back(bif.wr_addr);
      wd.push_back(bif.wr_data);
      if (bif.in_ready) rdy_bad++;
    end
    if (bif.done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " in_ready"}, 32'(bif.in_ready), 0);
    check({tag, " wr_en"}, 32'(bif.wr_en), 0);
    check({tag, " wr_addr"}, 32'(bif.wr_addr), 0);
    check({tag, " wr_data"}, bif.wr_data, 0);
    check({tag, " cpu_hold"}, 32'(bif.cpu_hold), 0);
    check({tag, " busy"}, 32'(bif.busy), 0);
    check({tag, " done"}, 32'(bif.done), 0);
    check({tag, " err"}, 32'(bif.err), 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 300) begin
      bif.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bif.in_byte  = bif.in_valid ? b : 8'($urandom);
      acc = bif.in_valid && bif.in_ready;
      tick();
      n++;
    end
    bif.in_valid = 1'b0;
    if (!acc) check("byte accept timeout", 0, 1);
  endtask

  function automatic logic [7:0] next_byte();
    if (bytes_q.size() > 0) return bytes_q.pop_front();
    return 8'($urandom);
  endfunction

  // Model: every 4 bytes form one big-endian word written to consecutive
  // addresses from 0; the checksum is the XOR of all data bytes.
  task automatic run_load(input string tag, input int len, input bit rnd,
                          input logic [7:0] cks_flip, input int spur);
    logic [7:0] b;
    logic [7:0] x;
    logic [31:0] w;
    int n;
    x = 8'h00;
    wa.delete(); wd.delete(); exp_words.delete();
    done_cnt = 0;
    rdy_bad = 0;
    bif.start = 1'b1;
    bif.load_len = 7'(len);
    tick();
    bif.start = 1'b0;
    check({tag, " cpu_hold after start"}, 32'(bif.cpu_hold), 1);
    check({tag, " err cleared by start"}, 32'(bif.err), 0);
    for (int i = 0; i < len; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) begin
        if (i * 4 + k == spur) begin
          bif.start = 1'b1;
          bif.load_len = 7'd1;
          tick();
          bif.start = 1'b0;
        end
        b = next_byte();
        x = x ^ b;
        w = {w[23:0], b};
        send_byte(b, rnd);
      end
      exp_words.push_back(w);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (len > 0) send_byte(x ^ cks_flip, rnd);
`endif
    n = 0;
    while (!bif.done && n < 40) begin
      tick();
      n++;
    end
    check({tag, " done seen"}, 32'(bif.done), 1);
    if (len == 0) check({tag, " done latency"}, n, 0);
    check({tag, " cpu_hold in done"}, 32'(bif.cpu_hold), 1);
    check({tag, " busy in done"}, 32'(bif.busy), 1);
    tick();
    check({tag, " done one cycle"}, 32'(bif.done), 0);
    check({tag, " cpu_hold released"}, 32'(bif.cpu_hold), 0);
    check({tag, " busy idle"}, 32'(bif.busy), 0);
    check({tag, " in_ready idle"}, 32'(bif.in_ready), 0);
    check({tag, " write count"}, wa.size(), len);
    for (int i = 0; i < len && i < wa.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), 32'(wa[i]), i);
      check($sformatf("%s data[%0d]", tag, i), wd[i], exp_words[i]);
    end
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " in_ready during write"}, rdy_bad, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check({tag, " err"}, 32'(bif.err), (len > 0 && cks_flip != 0) ? 1 : 0);
`else
    check({tag, " err"}, 32'(bif.err), 0);
`endif
  endtask

  initial begin
    reset = 1'b1;
    bif.start = 1'b1;
    bif.load_len = 7'd5;
    bif.in_valid = 1'b1;
    bif.in_byte = 8'hA5;
    tick();
    tick();
    check_idle("reset");
    bif.start = 1'b0;
    bif.in_valid = 1'b0;
    reset = 1'b0;
    tick();
    check_idle("post reset");

    bytes_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_load("single word", 1, 1'b0, 8'h00, -1);
    run_load("full depth", 64, 1'b1, 8'h00, -1);
    run_load("zero length", 0, 1'b0, 8'h00, -1);

    wa.delete(); wd.delete();
    bif.start = 1'b1;
    bif.load_len = 7'd8;
    tick();
    bif.start = 1'b0;
    for (int i = 0; i < 14; i++) send_byte(8'($urandom), 1'b0);
    reset = 1'b1;
    tick();
    check_idle("reset mid word");
    reset = 1'b0;
    tick();
    check_idle("after abort");
    check("abort write count", wa.size(), 3);
    check("abort last addr", (wa.size() > 0) ? 32'(wa[wa.size()-1]) : 32'hFFFF, 2);

    bytes_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load("after abort", 1, 1'b0, 8'h00, -1);
    run_load("spurious start", 3, 1'b1, 8'h00, 5);
    run_load("random short", 5, 1'b1, 8'h00, -1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load("checksum ok", 1, 1'b0, 8'h00, -1);
    bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load("checksum bad", 1, 1'b0, 8'h01, -1);
    tick();
    check("err sticky in idle", 32'(bif.err), 1);
    run_load("err cleared", 2, 1'b1, 8'h00, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
